// File: rtl/queue32_reader_pkg.sv
// queue32_reader_pkg: shared data word and skid-buffer occupancy types
package Type;
  typedef logic [31:0] Data32_T;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} QReaderState_T;
endpackage

// File: rtl/queue32_reader_register32.sv
// Register32: 32-bit storage cell that loads unless told to keep
module Register32 import Type::*; (
  input  logic    SIG_CLK,
  input  logic    SIG_RSTn,
  input  logic    CMD_KEEP,
  input  Data32_T DATA_IN,
  output Data32_T DATA_OUT
);
  // load on every edge the controller does not ask to keep
  always_ff @(posedge SIG_CLK)
    if (!SIG_RSTn) DATA_OUT <= '0;
    else if (!CMD_KEEP) DATA_OUT <= DATA_IN;
endmodule

// File: rtl/queue32_reader.sv
// queue32_reader: pops a 1-cycle-latency queue into a 2-entry skid buffer feeding a valid/ready consumer
module queue32_reader import Type::*; #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 SIG_CLK,
  input  logic                 SIG_RSTn,
  input  logic                 SIG_EMPTY,
  input  Data32_T              DATA_FROM_POP,
  output logic                 CMD_POP,
  input  logic                 CMD_FLUSH,
  output logic                 SIG_VALID,
  output Data32_T              DATA_OUT,
  input  logic                 SIG_READY,
  output logic [CNT_WIDTH-1:0] STAT_COUNT
);
  QReaderState_T        state, state_n;
  logic                 inflight, drop, retire, capture, keep_head, keep_tail;
  logic [2:0]           load;
  logic [CNT_WIDTH-1:0] count;
  Data32_T              head, tail, head_in;

  // occupancy, in-flight tracking, flush drop window and delivered-word counter
  always_ff @(posedge SIG_CLK)
    if (!SIG_RSTn) begin
      state    <= EMPTY;
      inflight <= 1'b0;
      drop     <= 1'b0;
      count    <= '0;
    end else begin
      state    <= state_n;
      inflight <= CMD_POP;
      drop     <= CMD_FLUSH;
      count    <= count + CNT_WIDTH'(retire);
    end

  // pop decision, next occupancy and which buffer entries load this edge
  always_comb begin
    SIG_VALID = state != EMPTY;
    retire    = SIG_VALID && SIG_READY;
    capture   = inflight && !CMD_FLUSH && !drop;
    load      = 3'(state) + 3'(inflight) - 3'(retire);
    CMD_POP   = SIG_RSTn && !SIG_EMPTY && !CMD_FLUSH && load < 3'd2;
    state_n   = CMD_FLUSH ? EMPTY : QReaderState_T'(state + 2'(capture) - 2'(retire));
    head_in   = state == TWO ? tail : DATA_FROM_POP;
    keep_head = !((state == EMPTY && capture) || (state == ONE && retire && capture) || (state == TWO && retire));
    keep_tail = !((state == ONE && capture && !retire) || (state == TWO && retire && capture));
  end

  Register32 u_head (
    .SIG_CLK (SIG_CLK),
    .SIG_RSTn(SIG_RSTn),
    .CMD_KEEP(keep_head),
    .DATA_IN (head_in),
    .DATA_OUT(head)
  );

  Register32 u_tail (
    .SIG_CLK (SIG_CLK),
    .SIG_RSTn(SIG_RSTn),
    .CMD_KEEP(keep_tail),
    .DATA_IN (DATA_FROM_POP),
    .DATA_OUT(tail)
  );

  assign DATA_OUT   = head;
  assign STAT_COUNT = count;

  // a capture into a full buffer without a retire would lose a word
  always_ff @(posedge SIG_CLK)
    if (SIG_RSTn) assert (!(capture && state == TWO && !retire)) else $error("queue32_reader skid buffer overflow");
endmodule

// File: doc/queue32_reader.md
QUEUE32_READER -- requirements
Module: queue32_reader

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the delivered-word counter.
REQ-002 SHALL have port SIG_CLK  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port SIG_RSTn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port SIG_EMPTY  input  1  queue has no word available to pop.
REQ-005 SHALL have port DATA_FROM_POP  input  Data32_T  queue read data, valid the cycle after CMD_POP.
REQ-006 SHALL have port CMD_POP  output  1  pop request to queue, one word per asserted cycle.
REQ-007 SHALL have port CMD_FLUSH  input  1  discard all buffered and in-flight words.
REQ-008 SHALL have port SIG_VALID  output  1  DATA_OUT holds a word for downstream.
REQ-009 SHALL have port DATA_OUT  output  Data32_T  head word to downstream.
REQ-010 SHALL have port SIG_READY  input  1  downstream accepts DATA_OUT this cycle.
REQ-011 SHALL have port STAT_COUNT  output  CNT_WIDTH  number of words delivered (VALID&&READY) since reset.

Function
REQ-012 SHALL hold up to 2 words in an in-order skid buffer; occupancy FSM states EMPTY(0), ONE(1), TWO(2).
REQ-013 SHALL track one in-flight bit: set the cycle after CMD_POP=1, meaning a word arrives on DATA_FROM_POP that cycle.
REQ-014 SHALL assert CMD_POP combinationally iff !SIG_EMPTY && !CMD_FLUSH && (occupancy + inflight - (SIG_VALID&&SIG_READY)) < 2.
REQ-015 SHALL capture DATA_FROM_POP into the tail of the buffer the cycle inflight=1, unless dropped per REQ-020.
REQ-016 SHALL drive SIG_VALID=1 iff occupancy>0; DATA_OUT SHALL be the oldest buffered word, registered (no combinational path from DATA_FROM_POP).
REQ-017 SHALL retire the head on SIG_VALID&&SIG_READY; second entry becomes head the next cycle.
REQ-018 SHALL keep DATA_OUT and SIG_VALID stable while SIG_VALID=1 and SIG_READY=0.
REQ-019 SHALL sustain one word per cycle with SIG_READY held 1 and SIG_EMPTY held 0; first word reaches SIG_VALID 2 cycles after CMD_POP (pop N, capture edge N+1, VALID at N+2).
REQ-020 On CMD_FLUSH=1: occupancy SHALL be 0 next cycle, a word arriving in the flush cycle or the cycle after (from a pop issued before flush) SHALL be dropped, CMD_POP SHALL be 0 in the flush cycle.
REQ-021 A handshake in the flush cycle SHALL still count in STAT_COUNT; flush has priority over capture.
REQ-022 Simultaneous capture and retire in TWO state SHALL leave occupancy 2 with order preserved; in ONE state occupancy stays 1 holding the new word.
REQ-023 STAT_COUNT SHALL increment by 1 per handshake and wrap from 2^CNT_WIDTH-1 to 0.
REQ-024 Capture SHALL never occur with occupancy 2 after retire (REQ-014 guarantees); an assertion SHALL flag overflow.

Reset
REQ-025 While SIG_RSTn=0 at a rising edge: occupancy 0, inflight 0, drop flag 0, STAT_COUNT 0, buffer data 32'b0.
REQ-026 During and after reset SIG_VALID=0, DATA_OUT=32'b0, CMD_POP=0 until SIG_RSTn=1 sampled; a word in flight at reset SHALL be discarded.

Structure
REQ-027 Data32_T and the occupancy enum QReaderState_T (EMPTY, ONE, TWO) SHALL live in package Type.
REQ-028 Each buffer entry SHALL be an instance of Register32, CMD_KEEP driven by the controller.
REQ-029 No other sub-modules; counter, FSM and pop logic local to queue32_reader.

Verification
REQ-030 Queue preloaded 0x11,0x22,0x33, READY=1 -> CMD_POP 3 consecutive cycles, DATA_OUT 0x11,0x22,0x33 on consecutive cycles, STAT_COUNT=3.
REQ-031 Queue 0xA0..0xA4, READY=0 for 6 cycles then 1 -> exactly 2 pops during stall, DATA_OUT=0xA0 held stable, then 0xA0..0xA4 in order with no loss.
REQ-032 Pop of 0xBEEF issued, CMD_FLUSH next cycle -> 0xBEEF never appears, SIG_VALID=0 after flush, next word 0xCAFE delivered normally.
REQ-033 READY toggled 1/0 every cycle with 8 queued words -> all 8 delivered in order, occupancy never exceeds 2.
REQ-034 SIG_RSTn=0 for one cycle with occupancy 2 and a pop in flight -> next cycle SIG_VALID=0, STAT_COUNT=0, CMD_POP reasserts only after reset released.
REQ-035 CNT_WIDTH=4, 17 handshakes -> STAT_COUNT=1 (wrap verified).
